// File: rtl/uart_pkg.sv
// Shared UART types: line configuration encodings and transmitter state codes.
// The parity and stop encodings are reused by the configurable receiver.
package uart_pkg;

    typedef enum logic [1:0] {
        PAR_NONE = 2'b00,
        PAR_EVEN = 2'b01,
        PAR_ODD  = 2'b10
    } parity_e;

    typedef enum logic [1:0] {
        STOP_1   = 2'b00,
        STOP_1P5 = 2'b01,
        STOP_2   = 2'b10
    } stop_e;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // The reserved code 2'b11 sends no parity bit.
    function automatic logic parity_enabled(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Word handshake between an upstream producer (or TX FIFO) and the transmitter,
// carrying the per-frame line configuration alongside the data word.
interface uart_tx_cfg_if #(
    parameter int DBIT = 8
);
    logic            tx_valid;
    logic            tx_ready;
    logic [DBIT-1:0] din;
    logic [1:0]      parity_mode;
    logic [1:0]      stop_mode;

    modport master (output tx_valid, din, parity_mode, stop_mode, input tx_ready);
    modport slave  (input tx_valid, din, parity_mode, stop_mode, output tx_ready);
endinterface

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter: DBIT data bits LSB first, optional parity,
// 1/1.5/2 stop bits, paced by an OS-times oversampling strobe.
module uart_tx_cfg
    import uart_pkg::*;
#(
    parameter int DBIT = 8,
    parameter int OS   = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         s_tick,
    uart_tx_cfg_if.slave bus,
    output logic         tx_busy,
    output logic         tx_done_tick,
    output logic         tx
);

    localparam int SW = $clog2(2 * OS);
    localparam int NW = $clog2(DBIT);

    localparam logic [SW-1:0] OS_LAST = SW'(OS - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);

    localparam logic [2:0] ST_IDLE   = IDLE;
    localparam logic [2:0] ST_START  = START;
    localparam logic [2:0] ST_DATA   = DATA;
    localparam logic [2:0] ST_PARITY = PARITY;
    localparam logic [2:0] ST_STOP   = STOP;

    // Last tick index of the stop period; the reserved code sends two stop bits.
    function automatic logic [SW-1:0] stop_last(input logic [1:0] mode);
        case (mode)
            STOP_1:   return SW'(OS - 1);
            STOP_1P5: return SW'(3 * OS / 2 - 1);
            default:  return SW'(2 * OS - 1);
        endcase
    endfunction

    logic [2:0]      state_reg, state_next;
    logic [SW-1:0]   s_reg, s_next;
    logic [NW-1:0]   n_reg, n_next;
    logic [DBIT-1:0] b_reg, b_next;
    logic [1:0]      par_reg, par_next;
    logic [1:0]      stop_reg, stop_next;
    logic            pbit_reg, pbit_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            par_reg   <= '0;
            stop_reg  <= '0;
            pbit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            par_reg   <= par_next;
            stop_reg  <= stop_next;
            pbit_reg  <= pbit_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        par_next     = par_reg;
        stop_next    = stop_reg;
        pbit_next    = pbit_reg;
        tx_done_tick = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Configuration and parity are frozen here for the whole frame.
                if (bus.tx_valid) begin
                    b_next     = bus.din;
                    par_next   = bus.parity_mode;
                    stop_next  = bus.stop_mode;
                    pbit_next  = (bus.parity_mode == PAR_ODD) ? ~^bus.din : ^bus.din;
                    s_next     = '0;
                    state_next = ST_START;
                end
            end
            ST_START: begin
                if (s_tick) begin
                    if (s_reg == OS_LAST) begin
                        s_next     = '0;
                        n_next     = '0;
                        state_next = ST_DATA;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            ST_DATA: begin
                if (s_tick) begin
                    if (s_reg == OS_LAST) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_LAST) begin
                            state_next = parity_enabled(par_reg) ? ST_PARITY : ST_STOP;
                        end else begin
                            n_next = n_reg + NW'(1);
                        end
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (s_tick) begin
                    if (s_reg == OS_LAST) begin
                        s_next     = '0;
                        state_next = ST_STOP;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            ST_STOP: begin
                if (s_tick) begin
                    if (s_reg == stop_last(stop_reg)) begin
                        s_next       = '0;
                        tx_done_tick = 1'b1;
                        state_next   = ST_IDLE;
                    end else begin
                        s_next = s_reg + SW'(1);
                    end
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_reg)
            ST_START:  tx = 1'b0;
            ST_DATA:   tx = b_reg[0];
            ST_PARITY: tx = pbit_reg;
            default:   tx = 1'b1;
        endcase
    end

    assign bus.tx_ready = (state_reg == ST_IDLE);
    assign tx_busy      = (state_reg != ST_IDLE);

endmodule
